// File: rtl/score_timer.sv
// Whack-a-mole game controller: BCD countdown timer, saturating BCD score and
// an IDLE/RUN/OVER state machine driving a four-digit display with blinking.
module score_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       start,
    input  logic       hit,
    input  logic       miss,
    input  logic       difficulty,
    output logic [3:0] digit0,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic [3:0] digit3,
    output logic       enable,
    output logic       blink,
    output logic       blink_enable,
    output logic       game_over
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OVER = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] tim_tens_q, tim_tens_d;
    logic [3:0] tim_ones_q, tim_ones_d;
    logic [3:0] sc_tens_q, sc_tens_d;
    logic [3:0] sc_ones_q, sc_ones_d;
    logic       blink_q, blink_d;
    logic       enable_q, enable_d;
    logic       blink_enable_q, blink_enable_d;
    logic       game_over_q, game_over_d;

    logic [3:0] start_tens;
    logic       timer_at_one;

    // Starting time is 60 s for easy and 30 s for hard.
    assign start_tens   = difficulty ? 4'd3 : 4'd6;
    assign timer_at_one = (tim_tens_q == 4'd0) && (tim_ones_q == 4'd1);

    always_comb begin
        state_d    = state_q;
        tim_tens_d = tim_tens_q;
        tim_ones_d = tim_ones_q;
        sc_tens_d  = sc_tens_q;
        sc_ones_d  = sc_ones_q;
        blink_d    = blink_q;

        case (state_q)
            IDLE: begin
                tim_tens_d = start_tens;
                tim_ones_d = 4'd0;
                sc_tens_d  = 4'd0;
                sc_ones_d  = 4'd0;
                blink_d    = 1'b0;
                if (start) begin
                    state_d = RUN;
                end
            end

            RUN: begin
                if (start) begin
                    tim_tens_d = start_tens;
                    tim_ones_d = 4'd0;
                    sc_tens_d  = 4'd0;
                    sc_ones_d  = 4'd0;
                end else begin
                    // Simultaneous hit and miss cancel out.
                    if (hit && !miss) begin
                        if (sc_tens_q == 4'd9 && sc_ones_q == 4'd9) begin
                            sc_tens_d = sc_tens_q;
                        end else if (sc_ones_q == 4'd9) begin
                            sc_ones_d = 4'd0;
                            sc_tens_d = sc_tens_q + 4'd1;
                        end else begin
                            sc_ones_d = sc_ones_q + 4'd1;
                        end
                    end else if (miss && !hit) begin
                        if (sc_tens_q == 4'd0 && sc_ones_q == 4'd0) begin
                            sc_tens_d = sc_tens_q;
                        end else if (sc_ones_q == 4'd0) begin
                            sc_ones_d = 4'd9;
                            sc_tens_d = sc_tens_q - 4'd1;
                        end else begin
                            sc_ones_d = sc_ones_q - 4'd1;
                        end
                    end

                    if (tick_1hz) begin
                        if (tim_ones_q == 4'd0) begin
                            tim_ones_d = 4'd9;
                            tim_tens_d = tim_tens_q - 4'd1;
                        end else begin
                            tim_ones_d = tim_ones_q - 4'd1;
                        end
                        if (timer_at_one) begin
                            state_d = OVER;
                            blink_d = 1'b0;
                        end
                    end
                end
            end

            OVER: begin
                if (start) begin
                    state_d    = IDLE;
                    blink_d    = 1'b0;
                    tim_tens_d = start_tens;
                    tim_ones_d = 4'd0;
                    sc_tens_d  = 4'd0;
                    sc_ones_d  = 4'd0;
                end else if (tick_1hz) begin
                    blink_d = ~blink_q;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        enable_d       = (state_d != IDLE);
        blink_enable_d = (state_d == OVER);
        game_over_d    = (state_d == OVER);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            tim_tens_q     <= start_tens;
            tim_ones_q     <= 4'd0;
            sc_tens_q      <= 4'd0;
            sc_ones_q      <= 4'd0;
            blink_q        <= 1'b0;
            enable_q       <= 1'b0;
            blink_enable_q <= 1'b0;
            game_over_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            tim_tens_q     <= tim_tens_d;
            tim_ones_q     <= tim_ones_d;
            sc_tens_q      <= sc_tens_d;
            sc_ones_q      <= sc_ones_d;
            blink_q        <= blink_d;
            enable_q       <= enable_d;
            blink_enable_q <= blink_enable_d;
            game_over_q    <= game_over_d;
        end
    end

    assign digit0       = tim_tens_q;
    assign digit1       = tim_ones_q;
    assign digit2       = sc_tens_q;
    assign digit3       = sc_ones_q;
    assign enable       = enable_q;
    assign blink        = blink_q;
    assign blink_enable = blink_enable_q;
    assign game_over    = game_over_q;

endmodule
